// File: rtl/vga_timing_pkg.sv
// Shared VGA mode descriptors and helpers for the raster timing generator.
package vga_timing_pkg;

  typedef struct packed {
    int h_display;
    int h_front;
    int h_sync;
    int h_back;
    int v_display;
    int v_front;
    int v_sync;
    int v_back;
  } vga_mode_t;

  function automatic int total(input int display, input int front,
                               input int sync, input int back);
    return display + front + sync + back;
  endfunction

  localparam vga_mode_t VGA_640X480  = '{640, 16, 96, 48, 480, 10, 2, 33};
  localparam vga_mode_t VGA_800X600  = '{800, 40, 128, 88, 600, 1, 4, 23};
  localparam vga_mode_t VGA_1280X720 = '{1280, 110, 40, 220, 720, 5, 5, 20};

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: counter register plus decode of its next state (active, sync).
// Outputs are combinational from the next state; holds when step_i is low.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int DISPLAY = 640,
  parameter int FRONT   = 16,
  parameter int SYNC    = 96,
  parameter int BACK    = 48,
  parameter bit POL     = 1'b0,
  localparam int TOTAL  = total(DISPLAY, FRONT, SYNC, BACK),
  localparam int W      = $clog2(TOTAL)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         step_i,
  output logic [W-1:0] cnt_nxt_o,
  output logic         wrap_o,
  output logic         active_nxt_o,
  output logic         sync_nxt_o
);

  localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
  localparam logic [W-1:0] DISP_END   = W'(DISPLAY);
  localparam logic [W-1:0] SYNC_START = W'(DISPLAY + FRONT);
  localparam logic [W-1:0] SYNC_END   = W'(DISPLAY + FRONT + SYNC);

  logic [W-1:0] cnt_q, cnt_d;
  logic         in_sync;

  always_comb begin
    wrap_o = step_i && (cnt_q == LAST);
    cnt_d  = cnt_q;
    if (wrap_o) begin
      cnt_d = '0;
    end else if (step_i) begin
      cnt_d = cnt_q + W'(1);
    end
    in_sync      = (cnt_d >= SYNC_START) && (cnt_d < SYNC_END);
    cnt_nxt_o    = cnt_d;
    active_nxt_o = cnt_d < DISP_END;
    sync_nxt_o   = in_sync ? POL : ~POL;
  end

  // Reset parks the counter on the last position so the first step lands on 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= LAST;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/DVI raster timing generator; 1-clk registered outputs, all regs hold while ce_i low.
// Optional 16-bit frame counter port with VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  localparam int H_TOTAL  = total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK),
  localparam int V_TOTAL  = total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK),
  localparam int HW       = $clog2(H_TOTAL),
  localparam int VW       = $clog2(V_TOTAL)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          ce_i,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          de_o,
  output logic [HW-1:0] hpos_o,
  output logic [VW-1:0] vpos_o,
  output logic          line_start_o,
  output logic          frame_start_o
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]   frame_cnt_o
`endif
);

  if (H_DISPLAY < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
      V_DISPLAY < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_param_err
    $error("vga_timing_gen: every H_*/V_* timing parameter must be >= 1");
  end

  logic [HW-1:0] h_nxt;
  logic          h_wrap, h_act, h_sync;
  logic [VW-1:0] v_nxt;
  logic          v_wrap, v_act, v_sync;

  vga_axis_counter #(
    .DISPLAY(H_DISPLAY), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .POL(HS_POL)
  ) u_h (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .step_i       (ce_i),
    .cnt_nxt_o    (h_nxt),
    .wrap_o       (h_wrap),
    .active_nxt_o (h_act),
    .sync_nxt_o   (h_sync)
  );

  // Stepping V on the H wrap keeps vsync edges aligned with hpos returning to 0.
  vga_axis_counter #(
    .DISPLAY(V_DISPLAY), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .POL(VS_POL)
  ) u_v (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .step_i       (h_wrap),
    .cnt_nxt_o    (v_nxt),
    .wrap_o       (v_wrap),
    .active_nxt_o (v_act),
    .sync_nxt_o   (v_sync)
  );

  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          de_q, de_d;
  logic [HW-1:0] hpos_q, hpos_d;
  logic [VW-1:0] vpos_q, vpos_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;

  always_comb begin
    hsync_d       = h_sync;
    vsync_d       = v_sync;
    de_d          = h_act && v_act;
    hpos_d        = h_nxt;
    vpos_d        = v_nxt;
    line_start_d  = h_wrap;
    frame_start_d = h_wrap && v_wrap;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      de_q          <= 1'b0;
      hpos_q        <= HW'(H_TOTAL - 1);
      vpos_q        <= VW'(V_TOTAL - 1);
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      hpos_q        <= hpos_d;
      vpos_q        <= vpos_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign de_o          = de_q;
  assign hpos_o        = hpos_q;
  assign vpos_o        = vpos_q;
  assign line_start_o  = line_start_q;
  assign frame_start_o = frame_start_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q + {15'd0, frame_start_d};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frame_cnt_q <= 16'd0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt_o = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a 15x8 raster (H 8/2/3/2, V 4/1/2/1).
module tb_vga_timing_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ce = 1'b0;
  logic       hs, vs, de, ls, fs;
  logic [3:0] hpos;
  logic [2:0] vpos;
  logic       hs_p, vs_p, de_p, ls_p, fs_p;
  logic [3:0] hpos_p;
  logic [2:0] vpos_p;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] fc, fc_p;
`endif

  int checks = 0;
  int errors = 0;
  int mh, mv;
  logic mls, mfs;
  logic [15:0] mfc;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .ce_i(ce),
    .hsync_o(hs), .vsync_o(vs), .de_o(de), .hpos_o(hpos), .vpos_o(vpos),
    .line_start_o(ls), .frame_start_o(fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt_o(fc)
`endif
  );

  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut_p (
    .clk_i(clk), .rst_ni(rst_n), .ce_i(ce),
    .hsync_o(hs_p), .vsync_o(vs_p), .de_o(de_p), .hpos_o(hpos_p), .vpos_o(vpos_p),
    .line_start_o(ls_p), .frame_start_o(fs_p)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt_o(fc_p)
`endif
  );

  // Expected {hs, vs, de, hpos, vpos, ls, fs} for the current model pixel.
  function automatic logic [11:0] exp_vec(input bit pol);
    logic h_in, v_in;
    h_in = (mh >= 10) && (mh <= 12);
    v_in = (mv >= 5) && (mv <= 6);
    return {pol ? h_in : ~h_in, pol ? v_in : ~v_in, (mh < 8) && (mv < 4),
            4'(mh), 3'(mv), mls, mfs};
  endfunction

  function automatic logic [11:0] obs_vec();
    return {hs, vs, de, hpos, vpos, ls, fs};
  endfunction

  // Called at a negedge; drives ce for one clk, advances the model, returns at the next negedge.
  task automatic tick(input bit c);
    ce = c;
    @(posedge clk);
    if (c) begin
      if (mh == 14) begin
        mh = 0;
        mv = (mv == 7) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
    end
    mls = c && (mh == 0);
    mfs = mls && (mv == 0);
    if (mfs) mfc = mfc + 16'd1;
    @(negedge clk);
  endtask

  task automatic model_reset();
    mh = 14; mv = 7; mls = 1'b0; mfs = 1'b0; mfc = 16'd0;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (obs_vec() !== 12'b1_1_0_1110_111_0_0) begin
      errors++; $display("FAIL reset_vec got %b want %b", obs_vec(), 12'b1_1_0_1110_111_0_0);
    end
    checks++;
    if ({hs_p, vs_p} !== 2'b00) begin
      errors++; $display("FAIL reset_pol got %b want 00", {hs_p, vs_p});
    end
`ifdef VGA_TIMING_FRAME_CNT_EN
    checks++;
    if (fc !== 16'd0) begin
      errors++; $display("FAIL reset_fc got %0d want 0", fc);
    end
`endif
    rst_n = 1'b1;
    tick(1'b0);
    tick(1'b0);
    checks++;
    if (obs_vec() !== 12'b1_1_0_1110_111_0_0) begin
      errors++; $display("FAIL idle_hold got %b want %b", obs_vec(), 12'b1_1_0_1110_111_0_0);
    end
  endtask

  task automatic test_ce_full();
    int de_cnt = 0;
    int fs_cnt = 0;
    int fs_first = -1;
    int fs_last = -1;
    for (int i = 0; i < 240; i++) begin
      tick(1'b1);
      if (i == 0) begin
        checks++;
        if ({fs, ls, hpos, vpos} !== {1'b1, 1'b1, 4'd0, 3'd0}) begin
          errors++; $display("FAIL first_pixel got %b want 1_1_0000_000", {fs, ls, hpos, vpos});
        end
      end
      checks++;
      if (obs_vec() !== exp_vec(1'b0)) begin
        errors++; $display("FAIL full_vec cyc %0d got %b want %b", i, obs_vec(), exp_vec(1'b0));
      end
      if (de) de_cnt++;
      if (fs) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = i;
        fs_last = i;
      end
    end
    checks++;
    if (de_cnt != 64) begin
      errors++; $display("FAIL de_count got %0d want 64", de_cnt);
    end
    checks++;
    if (fs_cnt != 2 || (fs_last - fs_first) != 120) begin
      errors++; $display("FAIL frame_period got %0d fs period %0d want 2 fs period 120",
                         fs_cnt, fs_last - fs_first);
    end
  endtask

  task automatic test_polarity();
    int hs_hi = 0;
    int vs_hi = 0;
    for (int i = 0; i < 120; i++) begin
      tick(1'b1);
      checks++;
      if ({hs_p, vs_p} !== exp_vec(1'b1)[11:10]) begin
        errors++; $display("FAIL pol_sync cyc %0d got %b want %b", i, {hs_p, vs_p}, exp_vec(1'b1)[11:10]);
      end
      if (hs_p) hs_hi++;
      if (vs_p) vs_hi++;
    end
    checks++;
    if (hs_hi != 24 || vs_hi != 30) begin
      errors++; $display("FAIL pol_counts got hs %0d vs %0d want hs 24 vs 30", hs_hi, vs_hi);
    end
  endtask

  task automatic test_vsync_edge();
    logic prev_vs;
    int edges = 0;
    prev_vs = vs;
    for (int i = 0; i < 120; i++) begin
      tick(1'b1);
      if (vs !== prev_vs) begin
        edges++;
        checks++;
        if (hpos !== 4'd0) begin
          errors++; $display("FAIL vsync_edge hpos got %0d want 0", hpos);
        end
      end
      prev_vs = vs;
    end
    checks++;
    if (edges != 2) begin
      errors++; $display("FAIL vsync_edge_count got %0d want 2", edges);
    end
  endtask

  task automatic test_ce_sparse();
    int ls_cnt = 0;
    int fs_cnt = 0;
    for (int i = 0; i < 360; i++) begin
      tick((i % 3) == 0);
      checks++;
      if (obs_vec() !== exp_vec(1'b0)) begin
        errors++; $display("FAIL sparse_vec cyc %0d got %b want %b", i, obs_vec(), exp_vec(1'b0));
      end
      if (ls) ls_cnt++;
      if (fs) fs_cnt++;
    end
    checks++;
    if (ls_cnt != 8 || fs_cnt != 1) begin
      errors++; $display("FAIL sparse_strobes got ls %0d fs %0d want ls 8 fs 1", ls_cnt, fs_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    while (!(mh == 5 && mv == 2) && n < 200) begin
      tick(1'b1);
      n++;
    end
    checks++;
    if ({hpos, vpos} !== {4'd5, 3'd2}) begin
      errors++; $display("FAIL mid_reach got %0d,%0d want 5,2", hpos, vpos);
    end
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (obs_vec() !== 12'b1_1_0_1110_111_0_0) begin
      errors++; $display("FAIL mid_reset got %b want %b", obs_vec(), 12'b1_1_0_1110_111_0_0);
    end
    @(negedge clk);
    tick(1'b1);
    rst_n = 1'b1;
    mls = 1'b0; mfs = 1'b0; mh = 14; mv = 7; mfc = 16'd0;
    tick(1'b0);
    checks++;
    if (obs_vec() !== 12'b1_1_0_1110_111_0_0) begin
      errors++; $display("FAIL mid_hold got %b want %b", obs_vec(), 12'b1_1_0_1110_111_0_0);
    end
`ifdef VGA_TIMING_FRAME_CNT_EN
    checks++;
    if (fc !== 16'd0) begin
      errors++; $display("FAIL mid_fc got %0d want 0", fc);
    end
`endif
    tick(1'b1);
    checks++;
    if (obs_vec() !== {1'b1, 1'b1, 1'b1, 4'd0, 3'd0, 1'b1, 1'b1}) begin
      errors++; $display("FAIL mid_restart got %b want 1_1_1_0000_000_1_1", obs_vec());
    end
  endtask

`ifdef VGA_TIMING_FRAME_CNT_EN
  task automatic test_frame_cnt();
    int n = 0;
    logic [15:0] want;
    checks++;
    if (fc !== 16'd1) begin
      errors++; $display("FAIL fc_first got %0d want 1", fc);
    end
    want = 16'd2;
    for (int i = 0; i < 240; i++) begin
      tick(1'b1);
      if (fs) begin
        checks++;
        if (fc !== want) begin
          errors++; $display("FAIL fc_step got %0d want %0d", fc, want);
        end
        want = want + 16'd1;
      end
    end
    checks++;
    if (fc !== 16'd3) begin
      errors++; $display("FAIL fc_three got %0d want 3", fc);
    end
    dut.frame_cnt_q = 16'hFFFF;
    tick(1'b1);
    while (!fs && n < 130) begin
      tick(1'b1);
      n++;
    end
    checks++;
    if (!fs || fc !== 16'd0) begin
      errors++; $display("FAIL fc_wrap got fs %b fc %0d want fs 1 fc 0", fs, fc);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_ce_full();
    test_polarity();
    test_vsync_edge();
    test_ce_sparse();
    test_reset_mid();
`ifdef VGA_TIMING_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA/DVI raster timing generator, successor to the fixed 640x480 sync generator. It produces aligned, registered `hsync_o`, `vsync_o`, `de_o` and pixel coordinates, plus line-start and frame-start strobes, for any mode set by parameters. It runs from a system clock gated by a pixel clock-enable. It sits between the clock/reset block and the pixel pipeline (pattern generator, framebuffer reader, TMDS encoder).

## Interface
- `H_DISPLAY`, 640: active pixels per line
- `H_FRONT`, 16: horizontal front porch, pixels
- `H_SYNC`, 96: hsync width, pixels
- `H_BACK`, 48: horizontal back porch, pixels
- `V_DISPLAY`, 480: active lines
- `V_FRONT`, 10: vertical front porch, lines
- `V_SYNC`, 2: vsync width, lines
- `V_BACK`, 33: vertical back porch, lines
- `HS_POL`, 0: hsync active level (0 = active-low)
- `VS_POL`, 0: vsync active level
- Derived: `H_TOTAL` = sum of the H_* parameters; `V_TOTAL` = sum of the V_* parameters; `HW` = $clog2(H_TOTAL); `VW` = $clog2(V_TOTAL)
- `clk_i`  in  1: system clock
- `rst_ni`  in  1: asynchronous active-low reset
- `ce_i`  in  1: pixel clock-enable; one pixel advance per cycle where high
- `hsync_o`  out  1: horizontal sync at HS_POL level
- `vsync_o`  out  1: vertical sync at VS_POL level
- `de_o`  out  1: data enable, high for active pixels
- `hpos_o`  out  HW: horizontal counter, 0..H_TOTAL-1
- `vpos_o`  out  VW: vertical counter, 0..V_TOTAL-1
- `line_start_o`  out  1: one-clk pulse when the outputs present hpos 0
- `frame_start_o`  out  1: one-clk pulse when the outputs present (0,0)
- `frame_cnt_o`  out  16: frame counter; present only with VGA_TIMING_FRAME_CNT_EN

## Operation
- Line order is active, then front porch, then sync, then back porch. The same order applies vertically.
- Hsync is active for `hpos` in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1].
- Vsync is active for `vpos` in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1]. It changes only together with `hpos` wrapping to 0.
- `de_o` = (`hpos` < H_DISPLAY) && (`vpos` < V_DISPLAY).
- Counters run through blanking. At `hpos` = H_TOTAL-1 with `ce_i` high: `hpos` goes to 0, and `vpos` increments, or wraps to 0 at V_TOTAL-1.
- All outputs are registers loaded from the decode of the next counter state. Every output therefore describes the same pixel in the same cycle, with no skew between syncs and `de_o`.
- Reset state (asynchronous):
  - Internal counters are at (H_TOTAL-1, V_TOTAL-1).
  - `hpos_o` = H_TOTAL-1 and `vpos_o` = V_TOTAL-1.
  - `de_o` = 0; `hsync_o` = ~HS_POL; `vsync_o` = ~VS_POL.
  - Both strobes = 0; `frame_cnt_o` = 0.
- The first `ce_i` after reset release presents pixel (0,0) with `frame_start_o` and `line_start_o` high.
- `ce_i` low: all registers hold. Strobes clear after one clk regardless of `ce_i`.
- Reset asserted mid-frame returns immediately to the reset state. There is no partial-frame flush.
- Elaboration checks: every H_*/V_* parameter must be >= 1. Violation is a `$error`.

## Timing
- Latency from a `ce_i` cycle to the outputs for that pixel is 1 clk (registered outputs).
- `line_start_o` is high for exactly 1 clk per line. `frame_start_o` is high for exactly 1 clk per frame and coincides with a `line_start_o`.
- With `ce_i` tied high, one frame is H_TOTAL*V_TOTAL clocks.
- Back-to-back `ce_i` is supported. Any `ce_i` duty cycle gives identical output sequences, stretched in time.

## Configuration
- `VGA_TIMING_FRAME_CNT_EN` defined: `frame_cnt_o` exists.
  - It increments, wrapping modulo 2^16, in the same cycle that `frame_start_o` rises. The first frame after reset reads 1.
- Not defined: the port and its counter are absent, and all other behaviour is identical.

## Structure
- Package `vga_timing_pkg` holds:
  - the `vga_mode_t` struct (display/front/sync/back for H and V);
  - localparam modes `VGA_640X480`, `VGA_800X600`, `VGA_1280X720`;
  - a `total()` function.
- Sub-module `vga_axis_counter` is instantiated twice, once for H and once for V.
  - Parameters: sizes, polarity.
  - Inputs: `step`.
  - Outputs: next value, wrap flag, next active, next sync.
  - The V instance steps on the H wrap flag.

## Test plan
- Small mode H 8/2/3/2 (H_TOTAL 15), V 4/1/2/1 (V_TOTAL 8), `ce_i`=1, after reset release -> `frame_start_o` on the first clk; `de_o` high for 8 clks per line on lines 0-3 only; `hsync_o` low for `hpos` 10-12; frame period 120 clks.
- Same mode, `ce_i` high every 3rd clk -> output sequence identical to the previous case sampled on `ce_i` cycles; strobes are exactly 1 clk wide.
- HS_POL=1, VS_POL=1 -> `hsync_o` high only for `hpos` 10-12 and `vsync_o` high only for `vpos` 5-6; reset levels are 0.
- Vsync edge check -> `vsync_o` changes only in the cycle where `hpos_o` becomes 0.
- Reset asserted at pixel (5,2) mid-frame -> outputs go to the reset values immediately; the next `ce_i` after release gives (0,0) with `frame_start_o`.
- With VGA_TIMING_FRAME_CNT_EN, run 3 frames -> `frame_cnt_o` reads 1, 2, 3, stepping at each `frame_start_o`. Preload 16'hFFFF -> the next frame reads 0.
